// File: rtl/coproc_ready_ctrl_pkg.sv
// Shared types and constants for the coprocessor ready/handshake controller.
// Used by coproc_ready_ctrl, its interface and its sub-module.
package coproc_pkg;

  localparam int READY_W  = 2;
  localparam int RDY_BIT  = 0;
  localparam int DONE_BIT = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    BUSY    = 3'd2,
    DONE    = 3'd3,
    RELEASE = 3'd4
  } coproc_state_t;

  // Encoding seen by the HPS: only IDLE shows ready and only DONE shows done.
  function automatic logic [READY_W-1:0] ready_code(input coproc_state_t s);
    logic [READY_W-1:0] r;
    r           = '0;
    r[RDY_BIT]  = (s == IDLE);
    r[DONE_BIT] = (s == DONE);
    return r;
  endfunction

endpackage

// File: rtl/coproc_ready_ctrl_if.sv
// HPS command/status and engine handshake bundle for coproc_ready_ctrl.
// slave = the controller's view, master = the HPS/engine side.
interface coproc_ready_ctrl_if;
  import coproc_pkg::*;

  logic               start_cmd;
  logic               ack_cmd;
  logic               engine_start;
  logic               engine_done;
  logic               engine_error;
  logic [READY_W-1:0] ready_signals;
  logic               status_err;
  logic               timeout_flag;

  modport slave (
    input  start_cmd, ack_cmd, engine_done, engine_error,
    output engine_start, ready_signals, status_err, timeout_flag
  );

  modport master (
    output start_cmd, ack_cmd, engine_done, engine_error,
    input  engine_start, ready_signals, status_err, timeout_flag
  );

endinterface

// File: rtl/coproc_ready_ctrl_rise_det.sv
// Registered rising-edge detector with asynchronous active-low reset.
module coproc_rise_det (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic din_q;

  // Reset the history to 1 so a level already high at reset release is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) din_q <= 1'b1;
    else          din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/coproc_ready_ctrl.sv
// Start/ack handshake sequencer for the matrix coprocessor, driving the HPS ready_signals PIO.
// Optional BUSY watchdog enabled by defining COPROC_WATCHDOG_EN.
module coproc_ready_ctrl
  import coproc_pkg::*;
#(
  parameter int START_PULSE_LEN = 1,
  parameter int TIMEOUT_CYCLES  = 1048576
) (
  input  logic               clk,
  input  logic               reset_n,
  coproc_ready_ctrl_if.slave bus
);

  localparam logic [3:0] PULSE_LEN = 4'(START_PULSE_LEN);

  if (START_PULSE_LEN < 1 || START_PULSE_LEN > 15 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("coproc_ready_ctrl: START_PULSE_LEN must be 1..15 and TIMEOUT_CYCLES at least 2");
  end

  coproc_state_t      state;
  logic [3:0]         pulse_cnt;
  logic               start_rise;
  logic               engine_start_q;
  logic               status_err_q;
  logic [READY_W-1:0] ready_q;

`ifdef COPROC_WATCHDOG_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;
`endif

  coproc_rise_det u_start_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (bus.start_cmd),
    .rise    (start_rise)
  );

  // Outputs are set alongside each transition so they always describe the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      pulse_cnt      <= '0;
      engine_start_q <= 1'b0;
      status_err_q   <= 1'b0;
      ready_q        <= '0;
`ifdef COPROC_WATCHDOG_EN
      wd_cnt         <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ready_q <= ready_code(IDLE);
          if (start_rise) begin
            state          <= LAUNCH;
            ready_q        <= ready_code(LAUNCH);
            engine_start_q <= 1'b1;
            pulse_cnt      <= 4'd1;
            status_err_q   <= 1'b0;
`ifdef COPROC_WATCHDOG_EN
            timeout_q      <= 1'b0;
`endif
          end
        end

        LAUNCH: begin
          if (bus.engine_done) begin
            state          <= DONE;
            ready_q        <= ready_code(DONE);
            engine_start_q <= 1'b0;
            status_err_q   <= bus.engine_error;
          end else if (pulse_cnt >= PULSE_LEN) begin
            state          <= BUSY;
            engine_start_q <= 1'b0;
`ifdef COPROC_WATCHDOG_EN
            wd_cnt         <= '0;
`endif
          end else if (pulse_cnt != 4'hF) begin
            pulse_cnt <= pulse_cnt + 4'd1;
          end
        end

        BUSY: begin
          if (bus.engine_done) begin
            state        <= DONE;
            ready_q      <= ready_code(DONE);
            status_err_q <= bus.engine_error;
`ifdef COPROC_WATCHDOG_EN
          end else if (wd_cnt == WD_LAST) begin
            state        <= DONE;
            ready_q      <= ready_code(DONE);
            status_err_q <= 1'b1;
            timeout_q    <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
`endif
          end
        end

        DONE: begin
          if (bus.ack_cmd) begin
            state   <= RELEASE;
            ready_q <= ready_code(RELEASE);
          end
        end

        // Both command levels must be low together so a stale start cannot relaunch.
        RELEASE: begin
          if (!bus.start_cmd && !bus.ack_cmd) begin
            state   <= IDLE;
            ready_q <= ready_code(IDLE);
          end
        end

        default: begin
          state          <= IDLE;
          ready_q        <= ready_code(IDLE);
          engine_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.engine_start  = engine_start_q;
  assign bus.ready_signals = ready_q;
  assign bus.status_err    = status_err_q;
`ifdef COPROC_WATCHDOG_EN
  assign bus.timeout_flag  = timeout_q;
`else
  assign bus.timeout_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_coproc_ready_ctrl.sv
// Scoreboard bench for coproc_ready_ctrl: two instances (pulse length 3 and 4) share stimulus.
// Expected {ready_signals, engine_start, status_err, timeout_flag} is queued per cycle.
module tb_coproc_ready_ctrl;

  logic clk;
  logic reset_n;

  coproc_ready_ctrl_if if3 ();
  coproc_ready_ctrl_if if4 ();

  coproc_ready_ctrl #(.START_PULSE_LEN(3), .TIMEOUT_CYCLES(16)) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if3)
  );

  coproc_ready_ctrl #(.START_PULSE_LEN(4), .TIMEOUT_CYCLES(16)) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if4)
  );

  // {done, ready, engine_start, status_err, timeout_flag}
  localparam logic [4:0] I  = 5'b01000;
  localparam logic [4:0] IE = 5'b01010;
  localparam logic [4:0] IT = 5'b01011;
  localparam logic [4:0] L  = 5'b00100;
  localparam logic [4:0] B  = 5'b00000;
  localparam logic [4:0] D  = 5'b10000;
  localparam logic [4:0] DE = 5'b10010;
  localparam logic [4:0] DT = 5'b10011;
  localparam logic [4:0] R  = 5'b00000;
  localparam logic [4:0] RE = 5'b00010;
  localparam logic [4:0] RT = 5'b00011;

  wire [4:0] obs3 = {if3.ready_signals, if3.engine_start, if3.status_err, if3.timeout_flag};
  wire [4:0] obs4 = {if4.ready_signals, if4.engine_start, if4.status_err, if4.timeout_flag};

  logic [9:0] expQ[$];
  string      tagQ[$];
  int         checkCount = 0;
  int         errorCount = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [4:0] observed, input logic [4:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s got %b expected %b", tag, observed, expected);
    end
  endtask

  // Called at a falling edge: drives inputs, queues what the next rising edge must produce.
  task automatic applyStimulus(input string tag, input logic s, input logic a, input logic d,
                               input logic e, input logic [4:0] exp3, input logic [4:0] exp4);
    if3.start_cmd = s;  if4.start_cmd = s;
    if3.ack_cmd = a;    if4.ack_cmd = a;
    if3.engine_done = d;  if4.engine_done = d;
    if3.engine_error = e; if4.engine_error = e;
    expQ.push_back({exp3, exp4});
    tagQ.push_back(tag);
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] exp;
    string      tag;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        exp = expQ.pop_front();
        tag = tagQ.pop_front();
        checkOutput({tag, "/d3"}, obs3, exp[9:5]);
        checkOutput({tag, "/d4"}, obs4, exp[4:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_n = 1'b0;
    if3.start_cmd = 1'b0;  if4.start_cmd = 1'b0;
    if3.ack_cmd = 1'b0;    if4.ack_cmd = 1'b0;
    if3.engine_done = 1'b0;  if4.engine_done = 1'b0;
    if3.engine_error = 1'b0; if4.engine_error = 1'b0;
    #2;
    checkOutput("reset/d3", obs3, 5'b00000);
    checkOutput("reset/d4", obs4, 5'b00000);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus("rst_rel", 0, 0, 0, 0, I, I);
    applyStimulus("idle", 0, 0, 0, 0, I, I);

    $display("[TB] basic handshake");
    applyStimulus("t1_rise", 1, 0, 0, 0, L, L);
    repeat (2) applyStimulus("t1_pulse", 1, 0, 0, 0, L, L);
    applyStimulus("t1_pulse_end", 1, 0, 0, 0, B, L);
    repeat (6) applyStimulus("t1_busy", 1, 0, 0, 0, B, B);
    applyStimulus("t1_done", 1, 0, 1, 0, D, D);
    repeat (2) applyStimulus("t1_hold", 1, 0, 0, 0, D, D);
    applyStimulus("t1_ack", 1, 1, 0, 0, R, R);
    applyStimulus("t1_rel", 1, 1, 0, 0, R, R);
    applyStimulus("t1_idle", 0, 0, 0, 0, I, I);
    applyStimulus("t1_idle2", 0, 0, 0, 0, I, I);

    $display("[TB] engine error");
    applyStimulus("t2_rise", 1, 0, 0, 0, L, L);
    repeat (2) applyStimulus("t2_pulse", 1, 0, 0, 0, L, L);
    applyStimulus("t2_pulse_end", 1, 0, 0, 0, B, L);
    applyStimulus("t2_done_err", 1, 0, 1, 1, DE, DE);
    applyStimulus("t2_hold", 1, 0, 0, 0, DE, DE);
    applyStimulus("t2_ack", 1, 1, 0, 0, RE, RE);
    applyStimulus("t2_idle", 0, 0, 0, 0, IE, IE);
    applyStimulus("t2_idle2", 0, 0, 0, 0, IE, IE);

    $display("[TB] start toggles while busy");
    applyStimulus("t3_rise_clr", 1, 0, 0, 0, L, L);
    repeat (2) applyStimulus("t3_pulse", 1, 0, 0, 0, L, L);
    applyStimulus("t3_pulse_end", 1, 0, 0, 0, B, L);
    applyStimulus("t3_tog0", 0, 0, 0, 0, B, B);
    applyStimulus("t3_tog1", 1, 0, 0, 0, B, B);
    applyStimulus("t3_tog0b", 0, 0, 0, 0, B, B);
    repeat (2) applyStimulus("t3_tog1b", 1, 0, 0, 0, B, B);
    applyStimulus("t3_done", 1, 0, 1, 0, D, D);
    applyStimulus("t3_hold", 1, 0, 0, 0, D, D);
    applyStimulus("t3_ack", 1, 1, 0, 0, R, R);
    repeat (2) applyStimulus("t3_stale_start", 1, 0, 0, 0, R, R);
    applyStimulus("t3_idle", 0, 0, 0, 0, I, I);
    applyStimulus("t3_stray_done", 0, 0, 1, 1, I, I);
    applyStimulus("t3_idle2", 0, 0, 0, 0, I, I);

    $display("[TB] done during launch");
    applyStimulus("t4_rise", 1, 0, 0, 0, L, L);
    applyStimulus("t4_early_done", 1, 0, 1, 0, D, D);
    applyStimulus("t4_hold", 1, 0, 0, 0, D, D);
    applyStimulus("t4_ack", 1, 1, 0, 0, R, R);
    applyStimulus("t4_idle", 0, 0, 0, 0, I, I);

`ifdef COPROC_WATCHDOG_EN
    $display("[TB] watchdog timeout");
    applyStimulus("t5_rise", 1, 0, 0, 0, L, L);
    repeat (2) applyStimulus("t5_pulse", 1, 0, 0, 0, L, L);
    applyStimulus("t5_pulse_end", 1, 0, 0, 0, B, L);
    repeat (15) applyStimulus("t5_busy", 1, 0, 0, 0, B, B);
    applyStimulus("t5_timeout3", 1, 0, 0, 0, DT, B);
    applyStimulus("t5_timeout4", 1, 0, 0, 0, DT, DT);
    applyStimulus("t5_ack", 1, 1, 0, 0, RT, RT);
    applyStimulus("t5_idle", 0, 0, 0, 0, IT, IT);
    applyStimulus("t5b_rise_clr", 1, 0, 0, 0, L, L);
    repeat (2) applyStimulus("t5b_pulse", 1, 0, 0, 0, L, L);
    applyStimulus("t5b_pulse_end", 1, 0, 0, 0, B, L);
    repeat (15) applyStimulus("t5b_busy", 1, 0, 0, 0, B, B);
    applyStimulus("t5b_done_wins", 1, 0, 1, 0, D, D);
    applyStimulus("t5b_ack", 1, 1, 0, 0, R, R);
    applyStimulus("t5b_idle", 0, 0, 0, 0, I, I);
`else
    $display("[TB] busy without watchdog");
    applyStimulus("t5_rise", 1, 0, 0, 0, L, L);
    repeat (2) applyStimulus("t5_pulse", 1, 0, 0, 0, L, L);
    applyStimulus("t5_pulse_end", 1, 0, 0, 0, B, L);
    repeat (40) applyStimulus("t5_busy_long", 1, 0, 0, 0, B, B);
    applyStimulus("t5_done", 1, 0, 1, 0, D, D);
    applyStimulus("t5_ack", 1, 1, 0, 0, R, R);
    applyStimulus("t5_idle", 0, 0, 0, 0, I, I);
`endif

    $display("[TB] reset mid-busy");
    applyStimulus("t6_rise", 1, 0, 0, 0, L, L);
    repeat (2) applyStimulus("t6_pulse", 1, 0, 0, 0, L, L);
    applyStimulus("t6_pulse_end", 1, 0, 0, 0, B, L);
    repeat (2) applyStimulus("t6_busy", 1, 0, 0, 0, B, B);
    reset_n = 1'b0;
    #1;
    checkOutput("t6_async_rst/d3", obs3, 5'b00000);
    checkOutput("t6_async_rst/d4", obs4, 5'b00000);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus("t6_rel_start_high", 1, 0, 0, 0, I, I);
    applyStimulus("t6_stray_done", 1, 0, 1, 0, I, I);
    applyStimulus("t6_hold_high", 1, 0, 0, 0, I, I);
    applyStimulus("t6_low", 0, 0, 0, 0, I, I);
    applyStimulus("t6_rerise", 1, 0, 0, 0, L, L);
    applyStimulus("t6_done", 1, 0, 1, 0, D, D);
    applyStimulus("t6_ack", 1, 1, 0, 0, R, R);
    applyStimulus("t6_idle", 0, 0, 0, 0, I, I);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
